// File: rtl/vpu_pkg.sv
// Shared types and sizing for the vector issue path.
package vpu_pkg;

    localparam int unsigned OPERAND_WIDTH = 8;
    localparam int unsigned VLANE_CNT     = 4;
    localparam int unsigned OPERAND_CNT   = 3;
    localparam int unsigned MAX_DELAY_LG2 = 4;
    localparam int unsigned DATA_WIDTH    = OPERAND_WIDTH * VLANE_CNT;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] sew;
        logic       vm;
    } vpu_exec_req_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        ISSUE   = 3'd2,
        EXEC    = 3'd3,
        RESP    = 3'd4
    } vpu_issue_state_t;

endpackage

// File: rtl/vpu_operand_collector.sv
// Operand buffers plus the collected-operand mask for one in-flight request.
module vpu_operand_collector
    import vpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   collect_en_i,
    input  logic [OPERAND_CNT-1:0] mask_i,
    input  logic [DATA_WIDTH-1:0]  operand_i [OPERAND_CNT],
    input  logic [OPERAND_CNT-1:0] operand_valid_i,
    output logic [DATA_WIDTH-1:0]  operand_o [OPERAND_CNT],
    output logic                   complete_c
);

    logic [OPERAND_CNT-1:0] collected_q;
    logic [OPERAND_CNT-1:0] hit;

    // Only strobes for required operands, and only while collecting, count.
    assign hit        = collect_en_i ? (operand_valid_i & mask_i) : '0;
    assign complete_c = collect_en_i && ((collected_q | hit) == mask_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collected_q <= '0;
            for (int i = 0; i < int'(OPERAND_CNT); i++) begin
                operand_o[i] <= '0;
            end
        end else begin
            if (clear_i) begin
                collected_q <= '0;
            end else begin
                collected_q <= collected_q | hit;
            end
            for (int i = 0; i < int'(OPERAND_CNT); i++) begin
                if (hit[i]) begin
                    operand_o[i] <= operand_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/vpu_exec_issuer.sv
// Accepts one vector op, gathers its operands, launches the execution unit
// and holds the result until the consumer takes it.
module vpu_exec_issuer
    import vpu_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  vpu_exec_req_t            req_op_func_i,
    input  logic [MAX_DELAY_LG2-1:0] req_delay_i,
    input  logic [OPERAND_CNT-1:0]   req_src_mask_i,
    input  logic [DATA_WIDTH-1:0]    operand_i [OPERAND_CNT],
    input  logic [OPERAND_CNT-1:0]   operand_valid_i,
    output logic                     exec_start_o,
    output vpu_exec_req_t            exec_op_func_o,
    output logic [MAX_DELAY_LG2-1:0] exec_delay_o,
    output logic [DATA_WIDTH-1:0]    exec_operand_o [OPERAND_CNT],
    output logic [OPERAND_CNT-1:0]   exec_operand_valid_o,
    input  logic [DATA_WIDTH-1:0]    exec_dout_i,
    input  logic                     exec_done_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATA_WIDTH-1:0]    rsp_dout_o,
    output logic                     busy_o,
    output logic [CNT_WIDTH-1:0]     done_cnt_o
);

    vpu_issue_state_t       state_q;
    vpu_issue_state_t       state_d;
    logic [OPERAND_CNT-1:0] mask_q;
    logic                   issued_q;
    logic                   accept;
    logic                   capture;
    logic                   complete_c;

    vpu_operand_collector u_collector (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (accept),
        .collect_en_i    (state_q == COLLECT),
        .mask_i          (mask_q),
        .operand_i       (operand_i),
        .operand_valid_i (operand_valid_i),
        .operand_o       (exec_operand_o),
        .complete_c      (complete_c)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = (req_src_mask_i == '0) ? ISSUE : COLLECT;
                end
            end
            COLLECT: begin
                if (complete_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (exec_done_i) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_o  <= 1'b1;
            exec_start_o <= 1'b0;
            rsp_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            issued_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_o  <= (state_d == IDLE);
            exec_start_o <= (state_d == ISSUE);
            rsp_valid_o  <= (state_d == RESP);
            busy_o       <= (state_d != IDLE);
            issued_q     <= (state_d == ISSUE) || (state_d == EXEC);
        end
    end

    assign exec_operand_valid_o = issued_q ? mask_q : '0;

    // Request fields, result capture and completion count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_op_func_o <= '0;
            exec_delay_o   <= '0;
            mask_q         <= '0;
            rsp_dout_o     <= '0;
            done_cnt_o     <= '0;
        end else begin
            if (accept) begin
                exec_op_func_o <= req_op_func_i;
                exec_delay_o   <= req_delay_i;
                mask_q         <= req_src_mask_i;
            end
            if (capture) begin
                rsp_dout_o <= exec_dout_i;
                done_cnt_o <= done_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vpu_exec_issuer.sv
// Randomised scoreboard bench for vpu_exec_issuer with a countdown execution-unit model.
module tb_vpu_exec_issuer;
    import vpu_pkg::*;

    localparam int unsigned TB_CNT_W = 4;
    localparam int unsigned OPW      = $bits(vpu_exec_req_t);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     req_valid_i;
    logic                     req_ready_o;
    vpu_exec_req_t            req_op_func_i;
    logic [MAX_DELAY_LG2-1:0] req_delay_i;
    logic [OPERAND_CNT-1:0]   req_src_mask_i;
    logic [DATA_WIDTH-1:0]    operand_i [OPERAND_CNT];
    logic [OPERAND_CNT-1:0]   operand_valid_i;
    logic                     exec_start_o;
    vpu_exec_req_t            exec_op_func_o;
    logic [MAX_DELAY_LG2-1:0] exec_delay_o;
    logic [DATA_WIDTH-1:0]    exec_operand_o [OPERAND_CNT];
    logic [OPERAND_CNT-1:0]   exec_operand_valid_o;
    logic [DATA_WIDTH-1:0]    exec_dout_i;
    logic                     exec_done_i;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [DATA_WIDTH-1:0]    rsp_dout_o;
    logic                     busy_o;
    logic [TB_CNT_W-1:0]      done_cnt_o;

    vpu_exec_issuer #(.CNT_WIDTH(TB_CNT_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_op_func_i        (req_op_func_i),
        .req_delay_i          (req_delay_i),
        .req_src_mask_i       (req_src_mask_i),
        .operand_i            (operand_i),
        .operand_valid_i      (operand_valid_i),
        .exec_start_o         (exec_start_o),
        .exec_op_func_o       (exec_op_func_o),
        .exec_delay_o         (exec_delay_o),
        .exec_operand_o       (exec_operand_o),
        .exec_operand_valid_o (exec_operand_valid_o),
        .exec_dout_i          (exec_dout_i),
        .exec_done_i          (exec_done_i),
        .rsp_valid_o          (rsp_valid_o),
        .rsp_ready_i          (rsp_ready_i),
        .rsp_dout_o           (rsp_dout_o),
        .busy_o               (busy_o),
        .done_cnt_o           (done_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Execution unit: loads the delay on start, done while its counter sits at zero.
    logic [MAX_DELAY_LG2-1:0] ex_cnt;
    logic [DATA_WIDTH-1:0]    salt = '0;
    always @(posedge clk or posedge rst) begin
        if (rst)                ex_cnt <= '0;
        else if (exec_start_o)  ex_cnt <= exec_delay_o;
        else if (ex_cnt != '0)  ex_cnt <= ex_cnt - 1'b1;
    end
    assign exec_done_i = (ex_cnt == '0);
    always_comb begin
        exec_dout_i = salt ^ DATA_WIDTH'(exec_op_func_o);
        for (int i = 0; i < int'(OPERAND_CNT); i++)
            if (exec_operand_valid_o[i]) exec_dout_i = exec_dout_i ^ exec_operand_o[i];
    end

    typedef struct {
        int unsigned                            start_cyc;
        int unsigned                            rsp_cyc;
        vpu_exec_req_t                          op;
        logic [MAX_DELAY_LG2-1:0]               delay;
        logic [OPERAND_CNT-1:0]                 mask;
        logic [OPERAND_CNT-1:0][DATA_WIDTH-1:0] opnd;
        logic [DATA_WIDTH-1:0]                  dout;
        logic [TB_CNT_W-1:0]                    cnt;
    } exp_t;

    typedef struct packed {
        logic [OPERAND_CNT-1:0]                 strobe;
        logic [OPERAND_CNT-1:0][DATA_WIDTH-1:0] data;
    } step_t;

    exp_t        exp_q[$];
    step_t       plan[$];
    int unsigned model_cnt = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fail_now(string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Reference: result = salt ^ op ^ xor of the last accepted value of each required operand.
    function automatic void push_exp(int unsigned c, vpu_exec_req_t op, logic [MAX_DELAY_LG2-1:0] dly,
                                     logic [OPERAND_CNT-1:0] mask,
                                     logic [OPERAND_CNT-1:0][DATA_WIDTH-1:0] fin);
        exp_t e;
        e.start_cyc = c + 1;
        e.rsp_cyc   = c + 3 + int'(dly);
        e.op        = op;
        e.delay     = dly;
        e.mask      = mask;
        e.opnd      = fin;
        e.dout      = salt ^ DATA_WIDTH'(op);
        for (int i = 0; i < int'(OPERAND_CNT); i++)
            if (mask[i]) e.dout = e.dout ^ fin[i];
        model_cnt   = (model_cnt + 1) % (1 << TB_CNT_W);
        e.cnt       = TB_CNT_W'(model_cnt);
        exp_q.push_back(e);
    endfunction

    // Monitor: start and response events are checked against the scoreboard head.
    exp_t mon_e;
    logic prev_start = 1'b0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (exec_start_o === 1'b1) begin
                if (prev_start) fail_now("start_longer_than_one_cycle");
                if (exp_q.size() == 0) fail_now("start_unexpected");
                else begin
                    mon_e = exp_q[0];
                    chk("start_cycle", 64'(cyc), 64'(mon_e.start_cyc));
                    chk("exec_op_func", 64'(exec_op_func_o), 64'(mon_e.op));
                    chk("exec_delay", 64'(exec_delay_o), 64'(mon_e.delay));
                    chk("exec_operand_valid", 64'(exec_operand_valid_o), 64'(mon_e.mask));
                    chk("busy_in_issue", 64'(busy_o), 64'd1);
                    for (int i = 0; i < int'(OPERAND_CNT); i++)
                        if (mon_e.mask[i]) chk("exec_operand", 64'(exec_operand_o[i]), 64'(mon_e.opnd[i]));
                end
            end
            if (rsp_valid_o === 1'b1) begin
                chk("req_ready_while_rsp", 64'(req_ready_o), 64'd0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) fail_now("rsp_unexpected");
                    else begin
                        mon_e = exp_q.pop_front();
                        chk("rsp_cycle", 64'(cyc), 64'(mon_e.rsp_cyc));
                        chk("done_cnt", 64'(done_cnt_o), 64'(mon_e.cnt));
                        chk("operand_valid_in_resp", 64'(exec_operand_valid_o), 64'd0);
                    end
                end
                chk("rsp_dout", 64'(rsp_dout_o), 64'(mon_e.dout));
            end
        end
        prev_start = exec_start_o;
        prev_valid = rsp_valid_o;
    end

    task automatic wait_idle();
        int n = 0;
        while (req_ready_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (req_ready_o !== 1'b1) fail_now("idle_timeout");
    endtask

    // Drives the request and the operand plan; plan[0] coincides with the acceptance cycle.
    task automatic issue_txn(input vpu_exec_req_t op, input logic [MAX_DELAY_LG2-1:0] dly,
                             input logic [OPERAND_CNT-1:0] mask);
        logic [OPERAND_CNT-1:0]                 col;
        logic [OPERAND_CNT-1:0][DATA_WIDTH-1:0] fin;
        bit complete;
        col = '0;
        fin = '0;
        complete = (mask == '0);
        wait_idle();
        salt           = $urandom;
        req_valid_i    = 1'b1;
        req_op_func_i  = op;
        req_delay_i    = dly;
        req_src_mask_i = mask;
        if (complete) push_exp(cyc, op, dly, mask, fin);
        if (plan.size() == 0) plan.push_back('0);
        foreach (plan[k]) begin
            operand_valid_i = plan[k].strobe;
            for (int i = 0; i < int'(OPERAND_CNT); i++) operand_i[i] = plan[k].data[i];
            if (k > 0 && !complete) begin
                for (int i = 0; i < int'(OPERAND_CNT); i++)
                    if (plan[k].strobe[i] && mask[i]) begin
                        fin[i] = plan[k].data[i];
                        col[i] = 1'b1;
                    end
                if (col == mask) begin
                    complete = 1'b1;
                    push_exp(cyc, op, dly, mask, fin);
                end
            end
            @(negedge clk);
            req_valid_i = 1'b0;
        end
        operand_valid_i = '0;
    endtask

    // Waits for the response with stray strobes, optionally holding rsp_ready low.
    task automatic finish_txn(input int hold);
        int n = 0;
        int h = hold;
        bit done = 1'b0;
        while (!done && n < 300) begin
            operand_valid_i = OPERAND_CNT'($urandom);
            for (int i = 0; i < int'(OPERAND_CNT); i++) operand_i[i] = $urandom;
            if (rsp_valid_o === 1'b1) begin
                if (h > 0) begin
                    h--;
                    rsp_ready_i = 1'b0;
                end else begin
                    rsp_ready_i = 1'b1;
                    done = 1'b1;
                end
            end else begin
                rsp_ready_i = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        rsp_ready_i     = 1'b0;
        operand_valid_i = '0;
        if (!done) fail_now("rsp_timeout");
    endtask

    task automatic add_step(input logic [OPERAND_CNT-1:0] s, input logic [DATA_WIDTH-1:0] d0,
                            input logic [DATA_WIDTH-1:0] d1, input logic [DATA_WIDTH-1:0] d2);
        step_t st;
        st.strobe  = s;
        st.data[0] = d0;
        st.data[1] = d1;
        st.data[2] = d2;
        plan.push_back(st);
    endtask

    task automatic rand_plan(input logic [OPERAND_CNT-1:0] mask);
        int len;
        step_t st;
        len = $urandom_range(2, 6);
        plan.delete();
        for (int k = 0; k < len; k++) begin
            st.strobe = OPERAND_CNT'($urandom & $urandom);
            for (int i = 0; i < int'(OPERAND_CNT); i++) st.data[i] = $urandom;
            plan.push_back(st);
        end
        for (int i = 0; i < int'(OPERAND_CNT); i++)
            if (mask[i]) begin
                int k;
                k = $urandom_range(1, len - 1);
                plan[k].strobe[i] = 1'b1;
            end
    endtask

    function automatic vpu_exec_req_t rand_op();
        return vpu_exec_req_t'(OPW'($urandom));
    endfunction

    initial begin
        rst             = 1'b1;
        req_valid_i     = 1'b0;
        req_op_func_i   = '0;
        req_delay_i     = '0;
        req_src_mask_i  = '0;
        operand_valid_i = '0;
        rsp_ready_i     = 1'b0;
        for (int i = 0; i < int'(OPERAND_CNT); i++) operand_i[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_req_ready", 64'(req_ready_o), 64'd1);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_exec_start", 64'(exec_start_o), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_operand_valid", 64'(exec_operand_valid_o), 64'd0);
        chk("reset_done_cnt", 64'(done_cnt_o), 64'd0);
        chk("reset_rsp_dout", 64'(rsp_dout_o), 64'd0);
        chk("reset_exec_op", 64'(exec_op_func_o), 64'd0);

        // Two-operand latency case: op0 two cycles before op1, delay 4.
        plan.delete();
        add_step(3'b000, 0, 0, 0);
        add_step(3'b001, 32'h1122_3344, 0, 0);
        add_step(3'b000, 0, 0, 0);
        add_step(3'b010, 0, 32'hA5A5_0F0F, 0);
        issue_txn(rand_op(), 4'd4, 3'b011);
        finish_txn(0);

        // No operands, zero delay.
        plan.delete();
        add_step(3'b000, 0, 0, 0);
        issue_txn(rand_op(), 4'd0, 3'b000);
        finish_txn(0);

        // Strobe during acceptance ignored; unmasked op2 strobe ignored.
        plan.delete();
        add_step(3'b001, 32'hAA, 0, 0);
        add_step(3'b101, 32'h55, 0, 32'hDEAD_BEEF);
        issue_txn(rand_op(), 4'd2, 3'b001);
        finish_txn(0);

        // Repeat strobe on op0 overwrites before op1 completes the set.
        plan.delete();
        add_step(3'b000, 0, 0, 0);
        add_step(3'b001, 32'hAA, 0, 0);
        add_step(3'b101, 32'h55, 0, 32'h1234_5678);
        add_step(3'b010, 0, 32'h0BAD_F00D, 0);
        issue_txn(rand_op(), 4'd1, 3'b011);
        finish_txn(0);

        // Consumer stalls for 10 cycles.
        plan.delete();
        add_step(3'b000, 0, 0, 0);
        add_step(3'b010, 0, 32'hCAFE_0001, 0);
        issue_txn(rand_op(), 4'd3, 3'b010);
        finish_txn(10);

        // Reset while executing: no response, counter cleared.
        plan.delete();
        add_step(3'b000, 0, 0, 0);
        issue_txn(rand_op(), 4'd15, 3'b000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_req_ready", 64'(req_ready_o), 64'd1);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("abort_operand_valid", 64'(exec_operand_valid_o), 64'd0);
        chk("abort_done_cnt", 64'(done_cnt_o), 64'd0);
        chk("abort_rsp_dout", 64'(rsp_dout_o), 64'd0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random traffic; long enough for the narrow counter to wrap twice.
        for (int t = 0; t < 40; t++) begin
            logic [OPERAND_CNT-1:0] m;
            m = OPERAND_CNT'($urandom);
            rand_plan(m);
            issue_txn(rand_op(), MAX_DELAY_LG2'($urandom), m);
            finish_txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vpu_exec_issuer.md
VPU_EXEC_ISSUER -- requirements
Module: vpu_exec_issuer

Interface
REQ-001 Parameter CNT_WIDTH, 16, width of the completed-operation counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid_i  in  1  issue request valid.
REQ-005 req_ready_o  out  1  issuer accepts a request this cycle.
REQ-006 req_op_func_i  in  vpu_exec_req_t  operation to issue.
REQ-007 req_delay_i  in  MAX_DELAY_LG2  execution latency for this operation.
REQ-008 req_src_mask_i  in  OPERAND_CNT  operands required by this operation.
REQ-009 operand_i[OPERAND_CNT]  in  OPERAND_WIDTH*VLANE_CNT each  operand data from the fetch path.
REQ-010 operand_valid_i  in  OPERAND_CNT  per-operand single-cycle arrival strobe.
REQ-011 exec_start_o  out  1  start pulse to the execution unit.
REQ-012 exec_op_func_o  out  vpu_exec_req_t  registered operation.
REQ-013 exec_delay_o  out  MAX_DELAY_LG2  registered delay.
REQ-014 exec_operand_o[OPERAND_CNT]  out  OPERAND_WIDTH*VLANE_CNT each  collected operands.
REQ-015 exec_operand_valid_o  out  OPERAND_CNT  collected-operand mask.
REQ-016 exec_dout_i  in  OPERAND_WIDTH*VLANE_CNT  execution-unit result.
REQ-017 exec_done_i  in  1  execution unit's counter-at-zero flag (level).
REQ-018 rsp_valid_o / rsp_ready_i  out/in  1/1  result handshake.
REQ-019 rsp_dout_o  out  OPERAND_WIDTH*VLANE_CNT  captured result.
REQ-020 busy_o  out  1  high in any state other than IDLE.
REQ-021 done_cnt_o  out  CNT_WIDTH  completed-operation count.

Function
REQ-022 FSM states: IDLE, COLLECT, ISSUE, EXEC, RESP.
REQ-023 req_ready_o = 1 only in IDLE; on req_valid_i&req_ready_o the block registers op_func, delay and mask, clears the collected mask, and goes to COLLECT (or to ISSUE if the mask is all-zero).
REQ-024 COLLECT: each operand_valid_i[i] with mask[i]=1 stores operand_i[i] and sets collected[i]; a repeat strobe overwrites the data; strobes for unmasked operands, or strobes in any other state, are ignored.
REQ-025 COLLECT -> ISSUE on the cycle after (collected | arrivals this cycle) == mask; simultaneous arrival of several operands is legal.
REQ-026 ISSUE: exec_start_o = 1 for exactly one cycle; the next state is EXEC.
REQ-027 exec_op_func_o, exec_delay_o, exec_operand_o and exec_operand_valid_o (= mask) hold stable from ISSUE through EXEC; otherwise exec_operand_valid_o = 0.
REQ-028 EXEC: exec_done_i is sampled starting from the first EXEC cycle; on the first cycle it is 1, exec_dout_i is captured into rsp_dout_o, done_cnt_o increments (wrapping at 2^CNT_WIDTH), and the next state is RESP.
REQ-029 Latency from the last operand strobe at cycle C: start at C+1, result capture at C+2+delay, rsp_valid_o at C+3+delay; with delay=0, capture occurs in the first EXEC cycle.
REQ-030 RESP: rsp_valid_o = 1 with rsp_dout_o stable until rsp_ready_i; on the handshake cycle the next state is IDLE, so back-to-back requests incur 1 idle cycle.
REQ-031 A new request is never accepted while rsp_valid_o is high.

Reset
REQ-032 rst forces IDLE asynchronously; req_ready_o is then 1, and exec_start_o, exec_operand_valid_o, rsp_valid_o and busy_o are 0.
REQ-033 rst clears rsp_dout_o, the operand buffers, done_cnt_o and all registered request fields to 0.
REQ-034 Reset mid-operation abandons the in-flight operation without any response; reset deassertion resumes in IDLE.

Structure
REQ-035 VPU_PKG holds vpu_exec_req_t, OPERAND_WIDTH, VLANE_CNT, OPERAND_CNT, MAX_DELAY_LG2 and the state enum vpu_issue_state_t.
REQ-036 Operand storage and mask tracking are a single sub-module, vpu_operand_collector; the FSM, counter and response register live in the top module.

Verification
REQ-037 Mask 3'b011, operand 0 at C-2 and operand 1 at C, delay 4 -> exec_start_o at C+1, rsp_valid_o at C+7 with rsp_dout_o = exec_dout_i, done_cnt_o = 1.
REQ-038 Mask 0, delay 0 -> start 1 cycle after acceptance; rsp_valid_o 3 cycles after acceptance.
REQ-039 Operand 0 strobed twice (0xAA then 0x55) plus an unmasked operand 2 strobe -> exec_operand_o[0] = 0x55 and exec_operand_valid_o = 3'b001.
REQ-040 rsp_ready_i held low 10 cycles -> rsp_valid_o and rsp_dout_o stable, req_ready_o = 0 throughout.
REQ-041 rst asserted in EXEC -> immediate IDLE, no response, done_cnt_o = 0; a following request completes normally.
REQ-042 done_cnt_o preloaded at 0xFFFF, one completion -> 0x0000.
